// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and condition-code type used by the decode/execute
// control slice.
package y86_pkg;

  localparam int WORD_W = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  function automatic logic isExcept(input logic [2:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

endpackage

// File: rtl/y86_dx_control_if.sv
// Pipeline-register view (D/E/M/W inputs) and decode/execute/control results
// exchanged between the pipeline top level and the dx control block.
interface y86_dx_control_if;
  import y86_pkg::*;

  logic [2:0]        D_stat;
  logic [3:0]        D_icode, D_ifun, D_rA, D_rB;
  logic [WORD_W-1:0] D_valC, D_valP;
  logic [2:0]        E_stat;
  logic [3:0]        E_icode, E_ifun, E_dstE, E_dstM;
  logic [WORD_W-1:0] E_valC, E_valA, E_valB;
  logic [3:0]        M_icode, M_dstE, M_dstM;
  logic [WORD_W-1:0] M_valE, m_valM;
  logic [2:0]        m_stat, W_stat;
  logic [3:0]        W_dstE, W_dstM;
  logic [WORD_W-1:0] W_valE, W_valM;

  logic [2:0]        d_stat, e_stat;
  logic [3:0]        d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [WORD_W-1:0] d_valC, d_valA, d_valB;
  logic [3:0]        e_icode, e_dstE, e_dstM;
  logic              e_Cnd;
  logic [WORD_W-1:0] e_valE, e_valA;
  logic              F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;

  modport master (
    output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
           E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
           M_icode, M_dstE, M_dstM, M_valE, m_valM, m_stat,
           W_stat, W_dstE, W_dstM, W_valE, W_valM,
    input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
           d_dstE, d_dstM, d_srcA, d_srcB,
           e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM,
           F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall
  );

  modport slave (
    input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
           E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
           M_icode, M_dstE, M_dstM, M_valE, m_valM, m_stat,
           W_stat, W_dstE, W_dstM, W_valE, W_valM,
    output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
           d_dstE, d_dstM, d_srcA, d_srcB,
           e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM,
           F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall
  );

endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit Y86 register file: two asynchronous read ports, two write ports.
module y86_regfile
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [WORD_W-1:0] rdA,
  output logic [WORD_W-1:0] rdB,
  input  logic [3:0]        dstE,
  input  logic [WORD_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [WORD_W-1:0] valM
);

  logic [WORD_W-1:0] regs [0:14];

  // dstM is written last so it overrides dstE when both name the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      if (dstE != REG_NONE) regs[dstE] <= valE;
      if (dstM != REG_NONE) regs[dstM] <= valM;
    end
  end

  assign rdA = (srcA == REG_NONE) ? '0 : regs[srcA];
  assign rdB = (srcB == REG_NONE) ? '0 : regs[srcB];

endmodule

// File: rtl/y86_dx_control.sv
// Y86-64 decode/execute datapath with operand forwarding, condition codes and
// pipeline hazard control.
module y86_dx_control
  import y86_pkg::*;
(
  input logic clk,
  input logic rst,
  y86_dx_control_if.slave dx
);

  logic [3:0]               srcA, srcB, dstE, dstM, eDstE;
  logic [WORD_W-1:0]        rfA, rfB, valA, valB;
  logic signed [WORD_W-1:0] aluA, aluB, aluRes;
  logic [3:0]               aluFun;
  cc_t                      cc, ccNext;
  logic                     cnd, loadUse, retHaz, mispredict;

  function automatic logic signed [WORD_W-1:0] aluCompute(
      input logic [3:0] fn, input logic signed [WORD_W-1:0] a, b);
    case (fn)
      A_SUB:   return b - a;
      A_AND:   return a & b;
      A_XOR:   return a ^ b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic condEval(input logic [3:0] fn, input cc_t c);
    case (fn)
      4'h0:    return 1'b1;
      4'h1:    return (c.sf ^ c.of) | c.zf;
      4'h2:    return c.sf ^ c.of;
      4'h3:    return c.zf;
      4'h4:    return !c.zf;
      4'h5:    return !(c.sf ^ c.of);
      4'h6:    return !(c.sf ^ c.of) && !c.zf;
      default: return 1'b0;
    endcase
  endfunction

  // Decode: register IDs
  always_comb begin
    srcA = REG_NONE;
    srcB = REG_NONE;
    dstE = REG_NONE;
    dstM = REG_NONE;
    case (dx.D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = dx.D_rA;
      I_RET, I_POPQ:                      srcA = RSP;
      default: ;
    endcase
    case (dx.D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = dx.D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = RSP;
      default: ;
    endcase
    case (dx.D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dstE = dx.D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dstE = RSP;
      default: ;
    endcase
    if (dx.D_icode == I_MRMOVQ || dx.D_icode == I_POPQ) dstM = dx.D_rA;
  end

  y86_regfile uRegfile (
    .clk  (clk),
    .rst  (rst),
    .srcA (srcA),
    .srcB (srcB),
    .rdA  (rfA),
    .rdB  (rfB),
    .dstE (dx.W_dstE),
    .valE (dx.W_valE),
    .dstM (dx.W_dstM),
    .valM (dx.W_valM)
  );

  // Forwarding: the youngest producer wins; ID F never forwards
  always_comb begin
    if (dx.D_icode == I_JXX || dx.D_icode == I_CALL) valA = dx.D_valP;
    else if (srcA == REG_NONE)  valA = '0;
    else if (srcA == eDstE)     valA = aluRes;
    else if (srcA == dx.M_dstM) valA = dx.m_valM;
    else if (srcA == dx.M_dstE) valA = dx.M_valE;
    else if (srcA == dx.W_dstM) valA = dx.W_valM;
    else if (srcA == dx.W_dstE) valA = dx.W_valE;
    else                        valA = rfA;

    if (srcB == REG_NONE)       valB = '0;
    else if (srcB == eDstE)     valB = aluRes;
    else if (srcB == dx.M_dstM) valB = dx.m_valM;
    else if (srcB == dx.M_dstE) valB = dx.M_valE;
    else if (srcB == dx.W_dstM) valB = dx.W_valM;
    else if (srcB == dx.W_dstE) valB = dx.W_valE;
    else                        valB = rfB;
  end

  // Execute: ALU operand selection and condition codes
  always_comb begin
    aluA = '0;
    aluB = '0;
    case (dx.E_icode)
      I_RRMOVQ, I_OPQ:             aluA = dx.E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: aluA = dx.E_valC;
      I_CALL, I_PUSHQ:             aluA = -64'sd8;
      I_RET, I_POPQ:               aluA = 64'sd8;
      default: ;
    endcase
    case (dx.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: aluB = dx.E_valB;
      default: ;
    endcase
    aluFun    = (dx.E_icode == I_OPQ) ? dx.E_ifun : A_ADD;
    aluRes    = aluCompute(aluFun, aluA, aluB);
    ccNext.zf = (aluRes == '0);
    ccNext.sf = aluRes[WORD_W-1];
    case (aluFun)
      A_ADD:   ccNext.of = (aluA[WORD_W-1] == aluB[WORD_W-1]) && (aluRes[WORD_W-1] != aluA[WORD_W-1]);
      A_SUB:   ccNext.of = (aluA[WORD_W-1] != aluB[WORD_W-1]) && (aluRes[WORD_W-1] != aluB[WORD_W-1]);
      default: ccNext.of = 1'b0;
    endcase
    cnd   = condEval(dx.E_ifun, cc);
    eDstE = (dx.E_icode == I_RRMOVQ && !cnd) ? REG_NONE : dx.E_dstE;
  end

  // CC is frozen once an exception is in the memory or writeback stage
  always_ff @(posedge clk) begin
    if (rst)
      cc <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    else if (dx.E_icode == I_OPQ && !isExcept(dx.m_stat) && !isExcept(dx.W_stat))
      cc <= ccNext;
  end

  assign loadUse = (dx.E_icode == I_MRMOVQ || dx.E_icode == I_POPQ) &&
                   (dx.E_dstM != REG_NONE) &&
                   (dx.E_dstM == srcA || dx.E_dstM == srcB);
  assign retHaz     = (dx.D_icode == I_RET) || (dx.E_icode == I_RET) || (dx.M_icode == I_RET);
  assign mispredict = (dx.E_icode == I_JXX) && !cnd;

  assign dx.d_stat   = dx.D_stat;
  assign dx.d_icode  = dx.D_icode;
  assign dx.d_ifun   = dx.D_ifun;
  assign dx.d_valC   = dx.D_valC;
  assign dx.d_valA   = valA;
  assign dx.d_valB   = valB;
  assign dx.d_dstE   = dstE;
  assign dx.d_dstM   = dstM;
  assign dx.d_srcA   = srcA;
  assign dx.d_srcB   = srcB;
  assign dx.e_stat   = dx.E_stat;
  assign dx.e_icode  = dx.E_icode;
  assign dx.e_Cnd    = cnd;
  assign dx.e_valE   = aluRes;
  assign dx.e_valA   = dx.E_valA;
  assign dx.e_dstE   = eDstE;
  assign dx.e_dstM   = dx.E_dstM;
  assign dx.F_stall  = loadUse | retHaz;
  assign dx.D_stall  = loadUse;
  assign dx.D_bubble = mispredict | (retHaz & !loadUse);
  assign dx.E_bubble = mispredict | loadUse;
  assign dx.M_bubble = isExcept(dx.m_stat) | isExcept(dx.W_stat);
  assign dx.W_stall  = isExcept(dx.W_stat);

endmodule

// File: tb/tb_y86_dx_control.sv
// Directed-vector bench for the Y86-64 decode/execute control block.
module tb_y86_dx_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  y86_dx_control_if dxIf ();

  y86_dx_control dut (
    .clk (clk),
    .rst (rst),
    .dx  (dxIf.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dxIf.D_stat = 3'd1; dxIf.D_icode = 4'h1; dxIf.D_ifun = 4'h0;
    dxIf.D_rA = 4'hF; dxIf.D_rB = 4'hF; dxIf.D_valC = '0; dxIf.D_valP = '0;
    dxIf.E_stat = 3'd1; dxIf.E_icode = 4'h1; dxIf.E_ifun = 4'h0;
    dxIf.E_valC = '0; dxIf.E_valA = '0; dxIf.E_valB = '0;
    dxIf.E_dstE = 4'hF; dxIf.E_dstM = 4'hF;
    dxIf.M_icode = 4'h1; dxIf.M_dstE = 4'hF; dxIf.M_dstM = 4'hF; dxIf.M_valE = '0;
    dxIf.m_valM = '0; dxIf.m_stat = 3'd1;
    dxIf.W_stat = 3'd1; dxIf.W_dstE = 4'hF; dxIf.W_dstM = 4'hF;
    dxIf.W_valE = '0; dxIf.W_valM = '0;
  endtask

  task automatic setOp(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b);
    dxIf.E_icode = icode; dxIf.E_ifun = ifun; dxIf.E_valA = a; dxIf.E_valB = b;
  endtask

  // Read a register through decode with no forwarding source active
  task automatic readReg(input logic [3:0] r, input string tag, input logic [63:0] exp);
    dxIf.D_icode = 4'h2; dxIf.D_rA = r;
    #1;
    check(tag, dxIf.d_valA, exp);
  endtask

  initial begin
    idle();
    tick();
    rst = 1'b0;

    // Write every register through the E port, then exercise dstM-wins
    for (int i = 0; i < 15; i++) begin
      dxIf.W_dstE = 4'(i); dxIf.W_valE = 64'h100 + 64'(i);
      tick();
    end
    dxIf.W_dstE = 4'hF;
    readReg(4'd5, "rf_r5", 64'h105);
    readReg(4'd14, "rf_r14", 64'h10E);
    dxIf.W_dstE = 4'd3; dxIf.W_valE = 64'hAA; dxIf.W_dstM = 4'd3; dxIf.W_valM = 64'hBB;
    readReg(4'd3, "fwd_W_dstM", 64'hBB);
    tick();
    dxIf.W_dstE = 4'hF; dxIf.W_dstM = 4'hF;
    readReg(4'd3, "rf_dstM_wins", 64'hBB);

    // Decode ID generation
    dxIf.D_icode = 4'hB; dxIf.D_rA = 4'd6; dxIf.D_rB = 4'd7;
    #1;
    check("pop_srcA", dxIf.d_srcA, 64'h4);
    check("pop_dstE", dxIf.d_dstE, 64'h4);
    check("pop_dstM", dxIf.d_dstM, 64'h6);
    dxIf.D_icode = 4'h3;
    #1;
    check("irmov_srcA", dxIf.d_srcA, 64'hF);
    check("irmov_dstE", dxIf.d_dstE, 64'h7);

    // Forwarding priority
    dxIf.D_icode = 4'h6; dxIf.D_rA = 4'd2; dxIf.D_rB = 4'd3;
    setOp(4'h6, 4'h0, 64'd2, 64'd3); dxIf.E_dstE = 4'd2;
    dxIf.M_dstE = 4'd2; dxIf.M_valE = 64'd9;
    #1;
    check("fwd_e_over_M", dxIf.d_valA, 64'd5);
    check("valB_regfile", dxIf.d_valB, 64'hBB);
    setOp(4'h1, 4'h0, 64'd0, 64'd0); dxIf.E_dstE = 4'hF;
    #1;
    check("fwd_M_valE", dxIf.d_valA, 64'd9);
    dxIf.M_dstM = 4'd2; dxIf.m_valM = 64'd7;
    #1;
    check("fwd_m_valM", dxIf.d_valA, 64'd7);
    dxIf.D_icode = 4'h7; dxIf.D_valP = 64'h1234;
    #1;
    check("valA_valP", dxIf.d_valA, 64'h1234);
    idle();

    // Hazards: load-use, ret, and both together
    setOp(4'h5, 4'h0, 64'd0, 64'd0); dxIf.E_dstM = 4'd3;
    dxIf.D_icode = 4'h6; dxIf.D_rA = 4'd1; dxIf.D_rB = 4'd3;
    #1;
    check("lu_F_stall", dxIf.F_stall, 64'd1);
    check("lu_D_stall", dxIf.D_stall, 64'd1);
    check("lu_E_bubble", dxIf.E_bubble, 64'd1);
    check("lu_D_bubble", dxIf.D_bubble, 64'd0);
    dxIf.D_icode = 4'h1; dxIf.E_dstM = 4'hF;
    #1;
    check("lu_none_F", dxIf.D_stall, 64'd0);
    idle();
    dxIf.M_icode = 4'h9;
    #1;
    check("ret_F_stall", dxIf.F_stall, 64'd1);
    check("ret_D_bubble", dxIf.D_bubble, 64'd1);
    check("ret_D_stall", dxIf.D_stall, 64'd0);
    dxIf.D_icode = 4'h9; setOp(4'hB, 4'h0, 64'd0, 64'h200); dxIf.E_dstM = 4'd4;
    #1;
    check("retlu_D_bubble", dxIf.D_bubble, 64'd0);
    check("retlu_E_bubble", dxIf.E_bubble, 64'd1);
    check("pop_valE", dxIf.e_valE, 64'h208);
    idle();

    // ALU operand selection
    setOp(4'hA, 4'h0, 64'd0, 64'h100);
    #1;
    check("push_valE", dxIf.e_valE, 64'hF8);
    setOp(4'h3, 4'h0, 64'd0, 64'h999); dxIf.E_valC = 64'h42;
    #1;
    check("irmov_valE", dxIf.e_valE, 64'h42);
    setOp(4'h6, 4'h2, 64'hF0, 64'h3C);
    #1;
    check("and_valE", dxIf.e_valE, 64'h30);
    idle();

    // Mispredict after a non-zero add
    setOp(4'h6, 4'h0, 64'd1, 64'd2);
    tick();
    setOp(4'h7, 4'h3, 64'd0, 64'd0);
    #1;
    check("jeq_Cnd", dxIf.e_Cnd, 64'd0);
    check("mis_D_bubble", dxIf.D_bubble, 64'd1);
    check("mis_E_bubble", dxIf.E_bubble, 64'd1);
    dxIf.E_ifun = 4'h4;
    #1;
    check("jne_Cnd", dxIf.e_Cnd, 64'd1);
    setOp(4'h2, 4'h1, 64'h77, 64'd0); dxIf.E_dstE = 4'd5;
    #1;
    check("cmovle_dstE", dxIf.e_dstE, 64'hF);
    check("cmov_valE", dxIf.e_valE, 64'h77);
    dxIf.E_ifun = 4'h0;
    #1;
    check("rrmov_dstE", dxIf.e_dstE, 64'h5);
    idle();

    // Subtraction, then CC freeze on a W exception
    setOp(4'h6, 4'h1, 64'd1, 64'd1);
    #1;
    check("sub_valE", dxIf.e_valE, 64'd0);
    tick();
    setOp(4'h7, 4'h3, 64'd0, 64'd0);
    #1;
    check("sub_ZF", dxIf.e_Cnd, 64'd1);
    setOp(4'h6, 4'h1, 64'd1, 64'd2); dxIf.W_stat = 3'd3;
    #1;
    check("exc_M_bubble", dxIf.M_bubble, 64'd1);
    check("exc_W_stall", dxIf.W_stall, 64'd1);
    tick();
    dxIf.W_stat = 3'd1; setOp(4'h7, 4'h3, 64'd0, 64'd0);
    #1;
    check("cc_frozen", dxIf.e_Cnd, 64'd1);
    dxIf.m_stat = 3'd4;
    #1;
    check("mstat_M_bubble", dxIf.M_bubble, 64'd1);
    check("mstat_W_stall", dxIf.W_stall, 64'd0);
    dxIf.m_stat = 3'd1;

    // Overflow on add and on sub
    setOp(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    tick();
    setOp(4'h7, 4'h2, 64'd0, 64'd0);
    #1;
    check("addof_jl", dxIf.e_Cnd, 64'd0);
    dxIf.E_ifun = 4'h6;
    #1;
    check("addof_jg", dxIf.e_Cnd, 64'd1);
    setOp(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000);
    #1;
    check("subof_valE", dxIf.e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    tick();
    setOp(4'h7, 4'h2, 64'd0, 64'd0);
    #1;
    check("subof_jl", dxIf.e_Cnd, 64'd1);
    dxIf.E_ifun = 4'h5;
    #1;
    check("subof_jge", dxIf.e_Cnd, 64'd0);
    setOp(4'h6, 4'h3, 64'd5, 64'd5);
    tick();
    setOp(4'h7, 4'h1, 64'd0, 64'd0);
    #1;
    check("xor_jle", dxIf.e_Cnd, 64'd1);
    dxIf.E_ifun = 4'h7;
    #1;
    check("ifun7_Cnd", dxIf.e_Cnd, 64'd0);

    // Reset wins over a same-edge writeback and CC update
    setOp(4'h6, 4'h0, 64'd1, 64'd2);
    tick();
    rst = 1'b1;
    dxIf.W_dstE = 4'd5; dxIf.W_valE = 64'h55;
    tick();
    rst = 1'b0;
    idle();
    setOp(4'h7, 4'h3, 64'd0, 64'd0);
    #1;
    check("rst_Cnd", dxIf.e_Cnd, 64'd1);
    for (int i = 0; i < 15; i++) readReg(4'(i), $sformatf("rst_r%0d", i), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
